// File: rtl/accum_requant_if.sv
// Bus bundle between the channel accumulator, accum_requant and the consuming layer.
interface accum_requant_if #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH   = 8,
    parameter int unsigned SHIFT_WIDTH = 5,
    parameter int unsigned FIFO_DEPTH  = 4
);
    localparam int unsigned CNT_W = 7;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                   stop_accum;
    logic [CNT_W-1:0]       acc_count;
    logic [DATA_WIDTH-1:0]  acc_data;
    logic [DATA_WIDTH-1:0]  bias;
    logic [SHIFT_WIDTH-1:0] shift;
    logic                   relu_en;
    logic [CNT_W-1:0]       expected_channels;
    logic                   clr_flags;
    logic [OUT_WIDTH-1:0]   out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [LVL_W-1:0]       fifo_level;
    logic                   sat_flag;
    logic                   overflow;
    logic                   chan_err;

    modport master (
        output stop_accum, acc_count, acc_data, bias, shift, relu_en,
               expected_channels, clr_flags, out_ready,
        input  out_data, out_valid, fifo_level, sat_flag, overflow, chan_err
    );

    modport slave (
        input  stop_accum, acc_count, acc_data, bias, shift, relu_en,
               expected_channels, clr_flags, out_ready,
        output out_data, out_valid, fifo_level, sat_flag, overflow, chan_err
    );
endinterface

// File: rtl/accum_requant.sv
// Post-accumulation requantizer: bias add, round-half-up shift, optional ReLU,
// saturation to OUT_WIDTH, and a fall-through output FIFO with sticky status flags.
module accum_requant #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH   = 8,
    parameter int unsigned SHIFT_WIDTH = 5,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    accum_requant_if.slave bus
);
    localparam int unsigned SUM_W = DATA_WIDTH + 1;
    localparam int unsigned RND_W = DATA_WIDTH + 2;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic signed [RND_W-1:0] OUT_MAX = RND_W'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [RND_W-1:0] OUT_MIN = ~OUT_MAX;

    logic                          cap_valid;
    logic                          a_valid;
    logic signed [DATA_WIDTH-1:0]  a_data;
    logic signed [DATA_WIDTH-1:0]  a_bias;
    logic [SHIFT_WIDTH-1:0]        a_shift;
    logic                          a_relu;
    logic                          s1_valid;
    logic signed [SUM_W-1:0]       s1_sum;
    logic [SHIFT_WIDTH-1:0]        s1_shift;
    logic                          s1_relu;
    logic                          s2_valid;
    logic signed [RND_W-1:0]       s2_r;
    logic                          s2_relu;

    logic signed [SUM_W-1:0]       sum_c;
    logic signed [RND_W-1:0]       sum_ext_c;
    logic signed [RND_W-1:0]       rnd_c;
    logic signed [RND_W-1:0]       r_c;
    logic signed [RND_W-1:0]       relu_c;
    logic [OUT_WIDTH-1:0]          q_c;
    logic                          clip_c;

    logic [OUT_WIDTH-1:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]              wr_ptr;
    logic [PTR_W-1:0]              rd_ptr;
    logic [LVL_W-1:0]              level;
    logic [LVL_W-1:0]              level_next_c;
    logic                          out_valid_q;
    logic                          full_c;
    logic                          pop_c;
    logic                          push_c;
    logic                          drop_c;

    logic                          sat_q;
    logic                          ovf_q;
    logic                          chan_q;
    logic                          chan_set_c;

    // S1 sum and S2 rounding shift; the extra headroom bits keep both wrap-free
    always_comb begin
        sum_c     = {a_data[DATA_WIDTH-1], a_data} + {a_bias[DATA_WIDTH-1], a_bias};
        sum_ext_c = {s1_sum[SUM_W-1], s1_sum};
        rnd_c     = '0;
        if (s1_shift != '0) begin
            rnd_c = RND_W'(1) << (s1_shift - SHIFT_WIDTH'(1));
        end
        r_c = (sum_ext_c + rnd_c) >>> s1_shift;
    end

    // S3: ReLU then clamp; only the clamp counts as saturation
    always_comb begin
        relu_c = s2_r;
        if (s2_relu && s2_r[RND_W-1]) begin
            relu_c = '0;
        end
        q_c    = relu_c[OUT_WIDTH-1:0];
        clip_c = 1'b0;
        if (relu_c > OUT_MAX) begin
            q_c    = OUT_MAX[OUT_WIDTH-1:0];
            clip_c = 1'b1;
        end else if (relu_c < OUT_MIN) begin
            q_c    = OUT_MIN[OUT_WIDTH-1:0];
            clip_c = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cap_valid <= 1'b0;
            a_valid   <= 1'b0;
            a_data    <= '0;
            a_bias    <= '0;
            a_shift   <= '0;
            a_relu    <= 1'b0;
            s1_valid  <= 1'b0;
            s1_sum    <= '0;
            s1_shift  <= '0;
            s1_relu   <= 1'b0;
            s2_valid  <= 1'b0;
            s2_r      <= '0;
            s2_relu   <= 1'b0;
        end else begin
            cap_valid <= bus.stop_accum;
            a_valid   <= cap_valid;
            s1_valid  <= a_valid;
            s2_valid  <= s1_valid;
            if (cap_valid) begin
                a_data  <= bus.acc_data;
                a_bias  <= bus.bias;
                a_shift <= bus.shift;
                a_relu  <= bus.relu_en;
            end
            if (a_valid) begin
                s1_sum   <= sum_c;
                s1_shift <= a_shift;
                s1_relu  <= a_relu;
            end
            if (s1_valid) begin
                s2_r    <= r_c;
                s2_relu <= s1_relu;
            end
        end
    end

    // A push into a full FIFO survives only when the head is popped on the same edge
    always_comb begin
        full_c       = (level == LVL_W'(FIFO_DEPTH));
        pop_c        = (level != '0) && bus.out_ready;
        push_c       = s2_valid && (!full_c || pop_c);
        drop_c       = s2_valid && full_c && !pop_c;
        level_next_c = level + LVL_W'(push_c) - LVL_W'(pop_c);
        chan_set_c   = bus.stop_accum && (bus.acc_count != bus.expected_channels);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem         <= '{default: '0};
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (push_c) begin
                mem[wr_ptr] <= q_c;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level       <= level_next_c;
            out_valid_q <= (level_next_c != '0);
        end
    end

    // Sticky flags: a set event on the clearing edge wins
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sat_q  <= 1'b0;
            ovf_q  <= 1'b0;
            chan_q <= 1'b0;
        end else begin
            sat_q  <= (s2_valid && clip_c) || (sat_q && !bus.clr_flags);
            ovf_q  <= drop_c || (ovf_q && !bus.clr_flags);
            chan_q <= chan_set_c || (chan_q && !bus.clr_flags);
        end
    end

    assign bus.out_data   = mem[rd_ptr];
    assign bus.out_valid  = out_valid_q;
    assign bus.fifo_level = level;
    assign bus.sat_flag   = sat_q;
    assign bus.overflow   = ovf_q;
    assign bus.chan_err   = chan_q;
endmodule

// File: tb/tb_accum_requant.sv
// Scoreboard bench for accum_requant: directed cases plus randomized traffic.
module tb_accum_requant;
    localparam int unsigned DW    = 32;
    localparam int unsigned OW    = 8;
    localparam int unsigned SW    = 5;
    localparam int unsigned DEPTH = 4;
    localparam logic [6:0]  EXP_CH = 7'd32;
    localparam longint      QMAX  = (longint'(1) << (OW - 1)) - 1;
    localparam longint      QMIN  = -QMAX - 1;

    typedef struct {
        logic [OW-1:0] val;
        bit            sat;
        bit            chan_bad;
        int            due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   rand_rdy = 1'b0;

    exp_t          pend[$];
    logic [OW-1:0] mq[$];
    bit            e_sat, e_ovf, e_chan;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    accum_requant_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .SHIFT_WIDTH(SW), .FIFO_DEPTH(DEPTH)) bus_if ();

    accum_requant #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .SHIFT_WIDTH(SW), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_if.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: exact integer arithmetic, floor division after adding half an LSB
    function automatic void ref_model(input int acc, input int b, input int sh, input bit relu,
                                      output logic [OW-1:0] val, output bit sat);
        longint s, n, d, r;
        s = longint'(acc) + longint'(b);
        if (sh == 0) begin
            r = s;
        end else begin
            d = longint'(1) << sh;
            n = s + d / 2;
            r = n / d;
            if ((n % d != 0) && (n < 0)) r = r - 1;
        end
        if (relu && r < 0) r = 0;
        sat = 1'b0;
        if (r > QMAX) begin
            r = QMAX;
            sat = 1'b1;
        end else if (r < QMIN) begin
            r = QMIN;
            sat = 1'b1;
        end
        val = OW'(r);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_pulse();
        bus_if.clr_flags = 1'b1;
        tick(1);
        bus_if.clr_flags = 1'b0;
    endtask

    // Drives one stop pulse then the operand cycle; call at posedge+#1, returns two cycles later
    task automatic issue(input int acc, input int b, input int sh, input bit relu,
                         input logic [6:0] cnt, input bit clr,
                         input bit use_exp, input logic [OW-1:0] xval, input bit xsat);
        exp_t          e;
        logic [OW-1:0] mv;
        bit            ms;
        ref_model(acc, b, sh, relu, mv, ms);
        e.val      = use_exp ? xval : mv;
        e.sat      = use_exp ? xsat : ms;
        e.chan_bad = (cnt != EXP_CH);
        e.due      = cyc + 5;
        pend.push_back(e);
        bus_if.stop_accum = 1'b1;
        bus_if.acc_count  = cnt;
        bus_if.clr_flags  = clr;
        bus_if.acc_data   = $urandom;
        bus_if.bias       = $urandom;
        bus_if.shift      = SW'($urandom);
        bus_if.relu_en    = 1'($urandom);
        tick(1);
        bus_if.stop_accum = 1'b0;
        bus_if.acc_count  = 7'($urandom);
        bus_if.clr_flags  = 1'b0;
        bus_if.acc_data   = acc;
        bus_if.bias       = b;
        bus_if.shift      = SW'(sh);
        bus_if.relu_en    = relu;
        tick(1);
        bus_if.acc_data   = $urandom;
        bus_if.bias       = $urandom;
        bus_if.shift      = SW'($urandom);
        bus_if.relu_en    = 1'($urandom);
    endtask

    initial begin : ready_driver
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) bus_if.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: replays each edge on the model queues, then compares every output
    initial begin : monitor
        bit   rdy_prev, clr_prev, pop, s_sat, s_ovf, s_chan;
        int   sz;
        exp_t e;
        rdy_prev = 1'b0;
        clr_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mq.delete();
                pend.delete();
                e_sat = 1'b0; e_ovf = 1'b0; e_chan = 1'b0;
                rdy_prev = 1'b0;
                clr_prev = 1'b0;
                check("rst_out_valid", 64'(bus_if.out_valid), 64'(0));
                check("rst_out_data", 64'(bus_if.out_data), 64'(0));
                check("rst_fifo_level", 64'(bus_if.fifo_level), 64'(0));
                check("rst_flags", 64'({bus_if.sat_flag, bus_if.overflow, bus_if.chan_err}), 64'(0));
            end else begin
                s_sat = 1'b0; s_ovf = 1'b0; s_chan = 1'b0;
                sz  = mq.size();
                pop = (sz > 0) && rdy_prev;
                if (pop) void'(mq.pop_front());
                foreach (pend[i]) if (pend[i].chan_bad && (pend[i].due - 4 == cyc)) s_chan = 1'b1;
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    e = pend.pop_front();
                    s_sat = e.sat;
                    if (sz == DEPTH && !pop) s_ovf = 1'b1;
                    else mq.push_back(e.val);
                end
                e_sat  = s_sat  || (e_sat  && !clr_prev);
                e_ovf  = s_ovf  || (e_ovf  && !clr_prev);
                e_chan = s_chan || (e_chan && !clr_prev);
                check("out_valid", 64'(bus_if.out_valid), 64'(mq.size() != 0));
                check("fifo_level", 64'(bus_if.fifo_level), 64'(mq.size()));
                if (mq.size() != 0) check("out_data", 64'(bus_if.out_data), 64'(mq[0]));
                check("sat_flag", 64'(bus_if.sat_flag), 64'(e_sat));
                check("overflow", 64'(bus_if.overflow), 64'(e_ovf));
                check("chan_err", 64'(bus_if.chan_err), 64'(e_chan));
                rdy_prev = bus_if.out_ready;
                clr_prev = bus_if.clr_flags;
            end
        end
    end

    initial begin : stimulus
        int         acc, b, sh;
        bit         relu;
        logic [6:0] cnt;
        bus_if.stop_accum        = 1'b0;
        bus_if.acc_count         = '0;
        bus_if.acc_data          = '0;
        bus_if.bias              = '0;
        bus_if.shift             = '0;
        bus_if.relu_en           = 1'b0;
        bus_if.expected_channels = EXP_CH;
        bus_if.clr_flags         = 1'b0;
        bus_if.out_ready         = 1'b0;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Arithmetic corner cases with hand-derived results
        bus_if.out_ready = 1'b1;
        issue(1000, 24, 3, 1'b0, EXP_CH, 1'b0, 1'b1, 8'h7F, 1'b1);
        issue(-100, 0, 2, 1'b0, EXP_CH, 1'b0, 1'b1, 8'hE7, 1'b0);
        issue(-100, 0, 2, 1'b1, EXP_CH, 1'b0, 1'b1, 8'h00, 1'b0);
        issue(5, -3, 0, 1'b0, EXP_CH, 1'b0, 1'b1, 8'h02, 1'b0);
        issue(int'(32'h8000_0000), -1, 0, 1'b0, EXP_CH, 1'b0, 1'b1, 8'h80, 1'b1);
        tick(8);

        // Channel-count mismatch, clear, and clear colliding with a new mismatch
        clr_pulse();
        issue(7, 0, 0, 1'b0, 7'd31, 1'b0, 1'b1, 8'h07, 1'b0);
        check("chan_err_t1", 64'(bus_if.chan_err), 64'(1));
        tick(6);
        clr_pulse();
        tick(1);
        check("chan_err_cleared", 64'(bus_if.chan_err), 64'(0));
        issue(8, 0, 0, 1'b0, 7'd31, 1'b0, 1'b1, 8'h08, 1'b0);
        issue(9, 0, 0, 1'b0, 7'd31, 1'b1, 1'b1, 8'h09, 1'b0);
        tick(1);
        check("chan_err_set_wins", 64'(bus_if.chan_err), 64'(1));
        tick(6);

        // Fill with consumer stalled: fifth result is dropped
        clr_pulse();
        bus_if.out_ready = 1'b0;
        for (int v = 1; v <= 5; v++) issue(v, 0, 0, 1'b0, EXP_CH, 1'b0, 1'b1, OW'(v), 1'b0);
        tick(6);
        check("full_level", 64'(bus_if.fifo_level), 64'(4));
        check("full_overflow", 64'(bus_if.overflow), 64'(1));
        check("full_head", 64'(bus_if.out_data), 64'(1));
        bus_if.out_ready = 1'b1;
        tick(8);
        check("drained_valid", 64'(bus_if.out_valid), 64'(0));

        // Push and pop on the same edge while full
        clr_pulse();
        bus_if.out_ready = 1'b0;
        for (int v = 11; v <= 14; v++) issue(v, 0, 0, 1'b0, EXP_CH, 1'b0, 1'b1, OW'(v), 1'b0);
        issue(15, 0, 0, 1'b0, EXP_CH, 1'b0, 1'b1, 8'd15, 1'b0);
        tick(2);
        bus_if.out_ready = 1'b1;
        tick(1);
        bus_if.out_ready = 1'b0;
        tick(1);
        check("pushpop_level", 64'(bus_if.fifo_level), 64'(4));
        check("pushpop_overflow", 64'(bus_if.overflow), 64'(0));
        check("pushpop_head", 64'(bus_if.out_data), 64'(12));
        bus_if.out_ready = 1'b1;
        tick(8);

        // Randomized traffic with a random consumer
        rand_rdy = 1'b1;
        repeat (200) begin
            if ($urandom_range(0, 1) == 1) acc = int'($urandom);
            else acc = int'($urandom_range(0, 4000)) - 2000;
            b    = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
            sh   = int'($urandom_range(0, 31));
            relu = 1'($urandom);
            cnt  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : EXP_CH;
            issue(acc, b, sh, relu, cnt, ($urandom_range(0, 15) == 0), 1'b0, '0, 1'b0);
            tick(int'($urandom_range(0, 2)));
        end
        rand_rdy = 1'b0;
        bus_if.out_ready = 1'b1;
        tick(12);

        // Reset with two results queued and two more in flight
        bus_if.out_ready = 1'b0;
        issue(1, 0, 0, 1'b0, EXP_CH, 1'b0, 1'b1, 8'd1, 1'b0);
        issue(2, 0, 0, 1'b0, EXP_CH, 1'b0, 1'b1, 8'd2, 1'b0);
        tick(4);
        issue(1000, 24, 3, 1'b0, 7'd5, 1'b0, 1'b1, 8'h7F, 1'b1);
        issue(3, 0, 0, 1'b0, EXP_CH, 1'b0, 1'b1, 8'd3, 1'b0);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        bus_if.out_ready = 1'b1;
        tick(10);
        check("post_reset_valid", 64'(bus_if.out_valid), 64'(0));
        check("post_reset_flags", 64'({bus_if.sat_flag, bus_if.overflow, bus_if.chan_err}), 64'(0));

        check("scoreboard_empty", 64'(mq.size() + pend.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
